linebuffer_window_ctrl: RTL and testbench

Sequencer for the two cascaded single-line pixel buffers feeding the 3x3 neighbourhood (edge/filter) stage.
- Accepts a raw pixel-valid stream with a frame-start pulse.
- Drives the frame-sync and row-sync enables of both line buffers.
- Tracks column and row position.
- Flags the cycles on which the aligned 3x3 window is complete, with its centre coordinate.
- Sits between the camera capture front end and the line buffers / window registers.

---
 rtl/linebuffer_pkg.sv | 22 ++
 rtl/pixel_pos_counter.sv | 46 ++++
 rtl/linebuffer_window_ctrl.sv | 124 ++++++++++++
 tb/tb_linebuffer_window_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// ---------------------------------------------------------------------------
// linebuffer_pkg : shared state encoding and window geometry for the
//                  line-buffer window sequencer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package linebuffer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESYNC = 3'd1,
    FILL   = 3'd2,
    ACTIVE = 3'd3,
    DONE   = 3'd4
  } lb_state_e;

  localparam int WIN_SIZE  = 3;
  localparam int FILL_ROWS = WIN_SIZE - 1;

endpackage

`default_nettype wire

// File: rtl/pixel_pos_counter.sv
// ---------------------------------------------------------------------------
// pixel_pos_counter : column/row position counter with clear, wrap and
//                     end-of-line / last-pixel flags.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_pos_counter #(
  parameter  int IMG_W = 320,
  parameter  int IMG_H = 240,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          line_end,
  output logic          last
);

  assign line_end = (col == CW'(IMG_W - 1));
  assign last     = line_end && (row == RW'(IMG_H - 1));

  // The final pixel wraps both counters so the idle frame reads (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (line_end) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/linebuffer_window_ctrl.sv
// ---------------------------------------------------------------------------
// linebuffer_window_ctrl : sequences two cascaded line buffers and flags
//                          complete 3x3 windows with their centre.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module linebuffer_window_ctrl
  import linebuffer_pkg::*;
#(
  parameter  int IMG_W = 320,
  parameter  int IMG_H = 240,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_valid,
  output logic          lb_fsync,
  output logic          lb_rsync,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          win_valid,
  output logic [CW-1:0] cen_col,
  output logic [RW-1:0] cen_row,
  output logic          frame_done,
  output logic          busy
);

  lb_state_e r_state;
  lb_state_e w_next;
  logic      w_accept;
  logic      w_clr;
  logic      w_line_end;
  logic      w_last;
  logic      w_win_hit;

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .en       (w_accept),
    .clr      (w_clr),
    .col      (col),
    .row      (row),
    .line_end (w_line_end),
    .last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    lb_fsync   = 1'b0;
    lb_rsync   = 1'b0;
    frame_done = 1'b0;
    w_accept   = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_next = FILL;
          w_clr  = 1'b1;
        end
      end
      RESYNC: begin
        w_clr  = 1'b1;
        w_next = FILL;
      end
      FILL, ACTIVE: begin
        lb_fsync = 1'b1;
        if (frame_start) begin
          w_next = RESYNC;
          w_clr  = 1'b1;
        end else if (pix_valid) begin
          w_accept = 1'b1;
          lb_rsync = 1'b1;
          // Two full rows must sit in the buffers before any window exists.
          if (r_state == FILL && w_line_end && row == RW'(FILL_ROWS - 1))
            w_next = ACTIVE;
          if (r_state == ACTIVE && w_last)
            w_next = DONE;
        end
      end
      DONE: begin
        lb_fsync   = 1'b1;
        frame_done = 1'b1;
        if (frame_start) begin
          w_next = RESYNC;
          w_clr  = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign w_win_hit = w_accept && (row >= RW'(FILL_ROWS)) && (col >= CW'(WIN_SIZE - 1));

  // Buffer read data is registered, so the window trails the accept by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      cen_col   <= '0;
      cen_row   <= '0;
    end else begin
      win_valid <= w_win_hit;
      if (w_win_hit) begin
        cen_col <= col - CW'(1);
        cen_row <= row - RW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linebuffer_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_linebuffer_window_ctrl : randomized bench for linebuffer_window_ctrl
//                             against a pixel-count reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_linebuffer_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic          lb_fsync, lb_rsync, win_valid, frame_done, busy;
  logic [CW-1:0] col, cen_col;
  logic [RW-1:0] row, cen_row;

  linebuffer_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .lb_fsync   (lb_fsync),
    .lb_rsync   (lb_rsync),
    .col        (col),
    .row        (row),
    .win_valid  (win_valid),
    .cen_col    (cen_col),
    .cen_row    (cen_row),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: frame phase flags plus count of accepted pixels.
  bit m_act = 0;
  bit m_rs  = 0;
  bit m_dn  = 0;
  int m_n   = 0;
  bit m_win = 0;
  int m_cc  = 0;
  int m_cr  = 0;

  int rs_cnt  = 0;
  int win_cnt = 0;
  int acc_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_rs = 0; m_dn = 0; m_n = 0; m_win = 0; m_cc = 0; m_cr = 0;
  endtask

  task automatic step(input bit fs, input bit pv);
    bit e_acc;
    bit was_dn;
    int x, y;
    @(negedge clk);
    frame_start = fs;
    pix_valid   = pv;
    #1;
    e_acc = m_act && pv && !fs;
    chk("lb_fsync",   int'(lb_fsync),   int'(m_act || m_dn));
    chk("lb_rsync",   int'(lb_rsync),   int'(e_acc));
    chk("col",        int'(col),        m_n % W);
    chk("row",        int'(row),        m_n / W);
    chk("win_valid",  int'(win_valid),  int'(m_win));
    if (m_win) begin
      chk("cen_col", int'(cen_col), m_cc);
      chk("cen_row", int'(cen_row), m_cr);
    end
    chk("frame_done", int'(frame_done), int'(m_dn));
    chk("busy",       int'(busy),       int'(m_act || m_rs || m_dn));
    if (lb_rsync)  rs_cnt++;
    if (win_valid) win_cnt++;
    if (e_acc)     acc_cnt++;
    @(posedge clk);
    was_dn = m_dn;
    if (e_acc) begin
      x = m_n % W;
      y = m_n / W;
      m_win = (x >= 2) && (y >= 2);
      m_cc  = x - 1;
      m_cr  = y - 1;
      m_n++;
      if (m_n == W * H) begin
        m_n = 0; m_act = 0; m_dn = 1;
      end
    end else begin
      m_win = 0;
    end
    if (m_rs) begin
      m_rs = 0; m_act = 1; m_n = 0;
    end else if (fs) begin
      if (m_act || was_dn) begin
        m_rs = 1; m_act = 0; m_dn = 0;
      end else begin
        m_act = 1;
      end
      m_n = 0;
    end else if (was_dn) begin
      m_dn = 0;
    end
  endtask

  // mode 0: continuous, 1: alternating, 2: random gaps
  task automatic run_accepts(input int k, input int mode);
    int start = acc_cnt;
    int cyc   = 0;
    bit pv;
    while ((acc_cnt - start) < k && cyc < 2000) begin
      case (mode)
        0:       pv = 1'b1;
        1:       pv = (cyc % 2) == 0;
        default: pv = 1'($urandom_range(0, 1));
      endcase
      step(1'b0, pv);
      cyc++;
    end
    if (cyc >= 2000) chk("accept_timeout", acc_cnt - start, k);
  endtask

  task automatic clear_counts();
    rs_cnt = 0; win_cnt = 0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_fsync", int'(lb_fsync), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_cen",   int'({cen_col, cen_row}), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: continuous frame
    step(1'b1, 1'b0);
    clear_counts();
    run_accepts(W * H, 0);
    step(1'b0, 1'b0);
    chk("t1_rsync_cnt", rs_cnt, 48);
    chk("t1_win_cnt",   win_cnt, 24);
    step(1'b0, 1'b0);

    // 2: alternating pix_valid, frame_start carries an ignored pixel
    step(1'b1, 1'b1);
    clear_counts();
    run_accepts(W * H, 1);
    step(1'b0, 1'b0);
    chk("t2_rsync_cnt", rs_cnt, 48);
    chk("t2_win_cnt",   win_cnt, 24);

    // 3: pixels while idle
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("t3_rsync_cnt", rs_cnt, 0);

    // 4: mid-frame frame_start forces a resync
    step(1'b1, 1'b0);
    run_accepts(3 * W + 4, 2);
    step(1'b0, 1'b0);
    chk("t4_col", int'(col), 4);
    chk("t4_row", int'(row), 3);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    clear_counts();
    run_accepts(W * H, 2);
    step(1'b0, 1'b0);
    chk("t4_win_cnt", win_cnt, 24);
    step(1'b0, 1'b0);

    // 5: asynchronous reset at row 4
    step(1'b1, 1'b0);
    run_accepts(4 * W + 3, 2);
    @(negedge clk);
    pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_fsync",  int'(lb_fsync), 0);
    chk("t5_rsync",  int'(lb_rsync), 0);
    chk("t5_pos",    int'({col, row}), 0);
    chk("t5_win",    int'(win_valid), 0);
    chk("t5_cen",    int'({cen_col, cen_row}), 0);
    chk("t5_done",   int'(frame_done), 0);
    chk("t5_busy",   int'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // 6: frame_start during the DONE cycle
    step(1'b1, 1'b0);
    run_accepts(W * H, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    clear_counts();
    run_accepts(W * H, 2);
    step(1'b0, 1'b0);
    chk("t6_win_cnt", win_cnt, 24);
    for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
